mem_port_arbiter: RTL

// - Shares one single-ported unified memory between the pipeline's instruction fetch (IF) and data access (MEM) stages.
// - Arbitrates between the two requesters, sequences the memory handshake and returns read data to the winner.
// - Drives per-requester stall outputs that freeze PC, IF_ID and the downstream registers while a request is outstanding.
// - Sits between the PC/IF_ID and EX_MEM/MEM_WB logic on one side and the memory model on the other.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_starve_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
//   arb_state_t : arbiter FSM encoding
//   owner_t     : which requester a grant belongs to
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_D,
    RESP_IF,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while an instruction fetch is waiting.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one data grant (ignored once saturated)
//   clr      : return to zero (wins over inc)
//   sat      : count has reached STARVE_MAX, IF must win the next arbitration
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  assign sat = (cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and data
// access (MEM). Grants one requester at a time, holds the memory request
// until acknowledged, and returns registered read data with a one-cycle
// valid pulse.
//   clk, rst                      : clock, asynchronous active-low reset
//   if_req/if_addr                : fetch request, held until if_valid
//   if_rdata/if_valid/if_stall    : fetch response and pipeline freeze
//   d_req/d_we/d_addr/d_wdata     : load/store request, held until d_valid
//   d_rdata/d_valid/d_stall       : load response (loads only) and freeze
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, stable until ack
//   mem_rdata/mem_ack             : memory completion, ack any latency >= 1
//
// state   | meaning
// IDLE    | arbitrate; grant drives mem_* on the next edge
// BUSY_IF | fetch outstanding, waiting for mem_ack
// BUSY_D  | load/store outstanding, waiting for mem_ack
// RESP_IF | if_valid cycle (suppressed if if_req dropped), no arbitration
// RESP_D  | d_valid cycle (suppressed if d_req dropped), no arbitration
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t state, state_nxt;
  owner_t     gnt_owner;
  logic       grant_d, grant_if;
  logic       starve_sat;
  logic       cnt_inc, cnt_clr;

  // Data wins ties (MEM holds the older instruction) unless IF has been
  // passed over STARVE_MAX times in a row.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || !starve_sat)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF: if (mem_ack) state_nxt = RESP_IF;
      BUSY_D:  if (mem_ack) state_nxt = RESP_D;
      RESP_IF: state_nxt = IDLE;
      RESP_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_owner = grant_d ? OWN_D : OWN_IF;
  assign cnt_inc   = grant_d && if_req;
  assign cnt_clr   = grant_if || ((state == IDLE) && !if_req);

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_ack outside BUSY_x is ignored, so a stray ack after reset is harmless.
  // A requester that dropped its req while busy still lets the access finish,
  // but gets neither a valid pulse nor new read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_d || grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= (gnt_owner == OWN_D) && d_we;
        mem_addr  <= (gnt_owner == OWN_D) ? d_addr : if_addr;
        mem_wdata <= d_wdata;
      end
      if (mem_ack && (state == BUSY_IF)) begin
        mem_req <= 1'b0;
        if (if_req) begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end
      end
      if (mem_ack && (state == BUSY_D)) begin
        mem_req <= 1'b0;
        if (d_req) begin
          d_valid <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;

endmodule
